// File: rtl/control_sequencer_if.sv
// Control-sequencer interface: bundles the decode inputs (opcode, ALU flags) and every
// control line the sequencer drives onto the SAP-1 datapath.
//   master : the sequencer (reads opcode/flags, drives control word, tstate, halted)
//   slave  : the datapath side (drives opcode/flags, reads controls)
interface control_sequencer_if;
  logic [3:0] opcode;      // IR upper nibble, valid from T4
  logic       carry_flag;  // ALU carry from last ADD/SUB
  logic       zero_flag;   // ALU zero from last ADD/SUB
  logic       Cp, Ep, Lm, CE, RamWe, Li, Ei;
  logic       Ain, ALowerIn, Aout, Bin, Su, Eu, Oin, Jmp;
  logic [5:0] tstate;      // one-hot T1..T6, bit0 = T1
  logic       halted;

  modport master (
    input  opcode, carry_flag, zero_flag,
    output Cp, Ep, Lm, CE, RamWe, Li, Ei, Ain, ALowerIn, Aout, Bin, Su, Eu, Oin, Jmp,
    output tstate, halted
  );

  modport slave (
    output opcode, carry_flag, zero_flag,
    input  Cp, Ep, Lm, CE, RamWe, Li, Ei, Ain, ALowerIn, Aout, Bin, Su, Eu, Oin, Jmp,
    input  tstate, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// SAP-1 controller/sequencer: T-state counter plus instruction decoder. Emits one
// control word per clock; holds no datapath storage.
// Ports:
//   clk  - system clock, state advances on rising edge
//   rst  - asynchronous active-high reset; forces T1 and zeroes all outputs while high
//   ctl  - control_sequencer_if.master: opcode/flags in, control lines/tstate/halted out
// Parameter HALT_ON_ILLEGAL: 1 makes opcodes 1000-1101 behave as HLT, 0 as NOP.
// Optional macro SHORT_CYCLE_EN: return to T1 right after the last non-empty execute state.
module control_sequencer #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input logic               clk,
  input logic               rst,
  control_sequencer_if.master ctl
);

  typedef enum logic [2:0] {StT1, StT2, StT3, StT4, StT5, StT6, StHalt} state_e;

`ifdef SHORT_CYCLE_EN
  localparam bit ShortCycle = 1'b1;
`else
  localparam bit ShortCycle = 1'b0;
`endif

  // Control word bit positions
  localparam int unsigned BCp = 14, BEp = 13, BLm = 12, BCE = 11, BRamWe = 10, BLi = 9;
  localparam int unsigned BEi = 8, BAin = 7, BALowerIn = 6, BAout = 5, BBin = 4, BSu = 3;
  localparam int unsigned BEu = 2, BOin = 1, BJmp = 0;

  state_e      state_q, state_d;
  logic        illegal, hlt_op, done_t4, done_t5;
  logic [14:0] word;
  logic [5:0]  tstate;

  assign illegal = ctl.opcode[3] & (ctl.opcode[2:1] != 2'b11);  // 1000..1101
  assign hlt_op  = (ctl.opcode == 4'hF) | (illegal & HALT_ON_ILLEGAL);
  // Early exit points: LDA/STA finish at T5, everything outside ADD/SUB/LDA/STA at T4
  assign done_t5 = ShortCycle & ((ctl.opcode == 4'h0) | (ctl.opcode == 4'h3));
  assign done_t4 = ShortCycle & (ctl.opcode[3:2] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StT1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3:    state_d = StT4;
      StT4:    state_d = hlt_op ? StHalt : (done_t4 ? StT1 : StT5);
      StT5:    state_d = done_t5 ? StT1 : StT6;
      StT6:    state_d = StT1;
      StHalt:  state_d = StHalt;
      default: state_d = StT1;
    endcase
  end

  always_comb begin
    word   = '0;
    tstate = 6'b000001;
    if (!rst) begin
      unique case (state_q)
        StT1: begin
          tstate = 6'b000001;
          word[BEp] = 1'b1;
          word[BLm] = 1'b1;
        end
        StT2: begin
          tstate = 6'b000010;
          word[BCp] = 1'b1;
        end
        StT3: begin
          tstate = 6'b000100;
          word[BCE] = 1'b1;
          word[BLi] = 1'b1;
        end
        StT4: begin
          tstate = 6'b001000;
          case (ctl.opcode)
            4'h0, 4'h1, 4'h2, 4'h3: begin
              word[BEi] = 1'b1;
              word[BLm] = 1'b1;
            end
            4'h4: begin
              word[BEi]       = 1'b1;
              word[BALowerIn] = 1'b1;
            end
            4'h5: begin
              word[BEi]  = 1'b1;
              word[BJmp] = 1'b1;
            end
            4'h6: begin
              word[BEi]  = 1'b1;
              word[BJmp] = ctl.carry_flag;
            end
            4'h7: begin
              word[BEi]  = 1'b1;
              word[BJmp] = ctl.zero_flag;
            end
            4'hE: begin
              word[BAout] = 1'b1;
              word[BOin]  = 1'b1;
            end
            default: ;
          endcase
        end
        StT5: begin
          tstate = 6'b010000;
          case (ctl.opcode)
            4'h0: begin
              word[BCE]  = 1'b1;
              word[BAin] = 1'b1;
            end
            4'h1, 4'h2: begin
              word[BCE] = 1'b1;
              word[BBin] = 1'b1;
            end
            4'h3: begin
              word[BAout]  = 1'b1;
              word[BRamWe] = 1'b1;
            end
            default: ;
          endcase
        end
        StT6: begin
          tstate = 6'b100000;
          if (ctl.opcode == 4'h1 || ctl.opcode == 4'h2) begin
            word[BEu]  = 1'b1;
            word[BAin] = 1'b1;
            word[BSu]  = (ctl.opcode == 4'h2);
          end
        end
        StHalt:  tstate = 6'b000000;
        default: tstate = 6'b000001;
      endcase
    end
  end

  assign ctl.Cp       = word[BCp];
  assign ctl.Ep       = word[BEp];
  assign ctl.Lm       = word[BLm];
  assign ctl.CE       = word[BCE];
  assign ctl.RamWe    = word[BRamWe];
  assign ctl.Li       = word[BLi];
  assign ctl.Ei       = word[BEi];
  assign ctl.Ain      = word[BAin];
  assign ctl.ALowerIn = word[BALowerIn];
  assign ctl.Aout     = word[BAout];
  assign ctl.Bin      = word[BBin];
  assign ctl.Su       = word[BSu];
  assign ctl.Eu       = word[BEu];
  assign ctl.Oin      = word[BOin];
  assign ctl.Jmp      = word[BJmp];
  assign ctl.tstate   = tstate;
  assign ctl.halted   = (state_q == StHalt) & ~rst;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- SAP-1 controller/sequencer: a T-state ring counter plus an instruction decoder.
- Drives every control line on the shared 8-bit bus, including the accumulator's Ain, ALowerIn and Aout, so it sits directly upstream of the accumulator.
- Takes the IR opcode nibble and the ALU flags as inputs, and emits one control word per clock.
- Purely a sequencer: it contains no datapath storage.

Parameters:
- HALT_ON_ILLEGAL, 0, when 1 an unused opcode executes as HLT; when 0 it executes as NOP.

Ports:
- clk  in  1  system clock; state advances on the rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  4  IR upper nibble; valid from T4 onward
- carry_flag  in  1  ALU carry from the last ADD/SUB
- zero_flag  in  1  ALU zero from the last ADD/SUB
- Cp  out  1  PC increment
- Ep  out  1  PC drives bus
- Lm  out  1  MAR load
- CE  out  1  RAM drives bus
- RamWe  out  1  RAM write from bus
- Li  out  1  IR load
- Ei  out  1  IR operand nibble drives bus[3:0]
- Ain  out  1  accumulator full load
- ALowerIn  out  1  accumulator lower-nibble load
- Aout  out  1  accumulator drives bus
- Bin  out  1  B register load
- Su  out  1  ALU subtract select
- Eu  out  1  ALU drives bus
- Oin  out  1  output register load
- Jmp  out  1  PC load from bus
- tstate  out  6  one-hot T1..T6 (bit0 = T1)
- halted  out  1  high in HALT

Behaviour:
- Clock, reset and decode
  - One clock domain: clk. Reset is asynchronous and active-high on rst.
  - While rst is high: state forced to T1, and all control outputs plus halted are 0 (outputs gated by rst).
  - tstate reads 6'b000001 during reset.
  - The first rising edge after rst falls executes T1, i.e. the T1 word is presented during that cycle.
  - Outputs are combinational from (state, opcode, flags). Each T-state lasts exactly one clk cycle.
- States: T1..T6 and HALT.
  - Default sequence: T1→T2→…→T6→T1.
  - HALT is absorbing; only rst leaves it.
- Fetch (all opcodes):
  - T1: Ep, Lm.
  - T2: Cp.
  - T3: CE, Li.
- Execute, listed as T4 / T5 / T6 ("-" means no signals asserted):
  - LDA 0000: Ei,Lm / CE,Ain / -
  - ADD 0001: Ei,Lm / CE,Bin / Eu,Ain
  - SUB 0010: Ei,Lm / CE,Bin / Su,Eu,Ain
  - STA 0011: Ei,Lm / Aout,RamWe / -
  - LDI 0100: Ei,ALowerIn / - / -
  - JMP 0101: Ei,Jmp / - / -
  - JC 0110: Ei plus Jmp only if carry_flag=1 / - / -. Flag is sampled combinationally during T4.
  - JZ 0111: Ei plus Jmp only if zero_flag=1 / - / -
  - OUT 1110: Aout,Oin / - / -
  - HLT 1111: no signals in T4. The next edge enters HALT.
  - 1000–1101: NOP (all execute states empty), or HLT when HALT_ON_ILLEGAL=1.
- HALT: all control outputs 0, halted=1, tstate=0.
- Invariant: at most one of Ep, CE, Ei, Aout, Eu is high in any cycle. The bench checks this every cycle.
- Invariant: Ain and ALowerIn are never high together.
- opcode changes during T1–T3 have no effect on outputs.
- Reset mid-instruction (any state including HALT): immediate return to T1 with outputs cleared. No partial write is completed after rst rises.

Optional Feature:
- Macro: SHORT_CYCLE_EN
- Defined: after the last non-empty execute state the sequencer returns to T1 on the next edge.
  - LDA/STA: T5→T1 (5 cycles).
  - LDI/JMP/JC/JZ/OUT/NOP: T4→T1 (4 cycles).
  - ADD/SUB: unchanged, 6 cycles.
  - HLT: unchanged.
- Undefined: every instruction takes exactly 6 cycles, as listed above.

Test Plan:
- Reset: rst=1 asserted mid-T5 of ADD → outputs 0 within the same cycle, no clk edge needed; after release, first cycle Ep=Lm=1, tstate=000001.
- Opcode 0001 (ADD) → T4 {Ei,Lm}, T5 {CE,Bin}, T6 {Eu,Ain}, Su=0; next cycle T1. Repeat with 0010 (SUB) → T6 adds Su=1.
- Opcode 0100 (LDI) → T4 ALowerIn=1 with Ain=0 and Ei=1. With SHORT_CYCLE_EN, T1 follows T4 (instruction period 4 cycles); without it, 6 cycles.
- Opcode 0110 (JC) with carry_flag=0 → Jmp=0 in T4; with carry_flag=1 → Jmp=1. Same check for 0111 (JZ) using zero_flag.
- Opcode 1111 (HLT) → halted=1 from the edge ending T4; all outputs stay 0 for 20 cycles; rst pulse → T1 resumes.
- Opcode 1010 with HALT_ON_ILLEGAL=0 → no execute signals, halted=0. With HALT_ON_ILLEGAL=1 → halted=1 after T4. Bus-driver one-hot check holds throughout all tests.
